// File: rtl/eth_tx_framer_if.sv
// Dibit stream bundle between the upstream buffer, the TX framer and the RMII pins.
// master drives the input dibits (upstream side); slave is the framer itself.
interface eth_tx_framer_if;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiov;
    logic [1:0] axiod;
    logic       busy;
    logic       drop;

    modport master (
        output axiiv, axiid,
        input  axiov, axiod, busy, drop
    );

    modport slave (
        input  axiiv, axiid,
        output axiov, axiod, busy, drop
    );
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble/SFD, 32-dibit payload delay, CRC-32 FCS, inter-packet gap.
// Optional macro ETH_TX_PAD_EN adds zero padding up to MIN_PAYLOAD_DIBITS before the FCS.
module eth_tx_framer #(
    parameter int unsigned IPG_DIBITS         = 48,
    parameter int unsigned MIN_PAYLOAD_DIBITS = 240
) (
    input logic            clk,
    input logic            rst,
    eth_tx_framer_if.slave bus
);
    localparam int unsigned IpgW = (IPG_DIBITS < 2) ? 1 : $clog2(IPG_DIBITS + 1);

    typedef enum logic [2:0] {StIdle, StPreamble, StPayload, StPad, StFcs, StIpg} state_t;

    state_t          state;
    logic            cap;
    logic            rej;
    logic            prev_v;
    logic [2:0]      line [32];  // {valid, dibit}; entry 31 is 32 cycles old
    logic [4:0]      idx;
    logic [IpgW-1:0] gap;
    logic [31:0]     crc;
    logic            txen;
    logic [1:0]      txd;
    logic            busy_r;
    logic            drop_r;
`ifdef ETH_TX_PAD_EN
    logic [10:0]     cnt;
`endif

    logic [2:0] head;
    logic       rise;
    logic       accept;

    assign head   = line[31];
    assign rise   = bus.axiiv && !prev_v;
    assign accept = (state == StIdle) && bus.axiiv && !rej;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 2; b++) begin
            r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            cap    <= 1'b0;
            rej    <= 1'b0;
            prev_v <= 1'b0;
            idx    <= '0;
            gap    <= '0;
            crc    <= '1;
            txen   <= 1'b0;
            txd    <= 2'b00;
            busy_r <= 1'b0;
            drop_r <= 1'b0;
            for (int i = 0; i < 32; i++) line[i] <= '0;
`ifdef ETH_TX_PAD_EN
            cnt    <= '0;
`endif
        end else begin
            prev_v <= bus.axiiv;
            drop_r <= 1'b0;

            // Delay line runs every cycle; only captured dibits are marked valid.
            line[0] <= {accept || (cap && bus.axiiv), bus.axiid};
            for (int i = 1; i < 32; i++) line[i] <= line[i-1];

            if (!bus.axiiv) begin
                cap <= 1'b0;
                rej <= 1'b0;
            end else if (rise && state != StIdle && !cap) begin
                rej    <= 1'b1;
                drop_r <= 1'b1;
            end

`ifdef ETH_TX_PAD_EN
            if (accept) cnt <= 11'd1;
            else if (cap && bus.axiiv && cnt != 11'h7ff) cnt <= cnt + 11'd1;
`endif

            case (state)
                StIdle: begin
                    txen <= 1'b0;
                    txd  <= 2'b00;
                    crc  <= '1;
                    if (accept) begin
                        state  <= StPreamble;
                        cap    <= 1'b1;
                        busy_r <= 1'b1;
                        txen   <= 1'b1;
                        txd    <= 2'b01;
                        idx    <= 5'd1;
                    end
                end
                StPreamble: begin
                    txd <= (idx == 5'd31) ? 2'b11 : 2'b01;
                    idx <= idx + 5'd1;
                    if (idx == 5'd31) state <= StPayload;
                end
                StPayload: begin
                    // An empty head implies capture has ended: fill and drain rates match.
                    if (head[2]) begin
                        txd <= head[1:0];
                        crc <= crc_step(crc, head[1:0]);
                    end
`ifdef ETH_TX_PAD_EN
                    else if (cnt < 11'(MIN_PAYLOAD_DIBITS)) begin
                        txd   <= 2'b00;
                        crc   <= crc_step(crc, 2'b00);
                        cnt   <= cnt + 11'd1;
                        state <= StPad;
                    end
`endif
                    else begin
                        txd   <= ~crc[1:0];
                        crc   <= crc >> 2;
                        idx   <= 5'd1;
                        state <= StFcs;
                    end
                end
`ifdef ETH_TX_PAD_EN
                StPad: begin
                    if (cnt < 11'(MIN_PAYLOAD_DIBITS)) begin
                        txd <= 2'b00;
                        crc <= crc_step(crc, 2'b00);
                        cnt <= cnt + 11'd1;
                    end else begin
                        txd   <= ~crc[1:0];
                        crc   <= crc >> 2;
                        idx   <= 5'd1;
                        state <= StFcs;
                    end
                end
`endif
                StFcs: begin
                    txd <= ~crc[1:0];
                    crc <= crc >> 2;
                    idx <= idx + 5'd1;
                    if (idx == 5'd15) begin
                        state <= StIpg;
                        gap   <= '0;
                    end
                end
                StIpg: begin
                    txen <= 1'b0;
                    txd  <= 2'b00;
                    if (gap == IpgW'(IPG_DIBITS)) begin
                        state  <= StIdle;
                        busy_r <= 1'b0;
                    end else begin
                        gap <= gap + IpgW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.axiov = txen;
    assign bus.axiod = txd;
    assign bus.busy  = busy_r;
    assign bus.drop  = drop_r;
endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: stimulus queues expected wire frames, a negedge
// monitor pops and compares them, along with start time, drop pulses and the gap length.
module tb_eth_tx_framer;
    localparam int unsigned Ipg = 48;
    localparam int unsigned MinPay = 240;

    logic clk;
    logic rst;
    bit   in_reset;
    int   cyc;
    int   checks;
    int   fails;

    logic [1:0] pay[$];
    logic [1:0] exp_d[$];
    int         exp_len[$];
    int         start_q[$];
    int         drop_q[$];

    eth_tx_framer_if bus();

    eth_tx_framer #(
        .IPG_DIBITS        (Ipg),
        .MIN_PAYLOAD_DIBITS(MinPay)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(900000);
        $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.axiiv = 1'b0;
            bus.axiid = 2'($urandom);
            tick();
        end
    endtask

    // Reference frame: preamble bytes, payload (+pad), CRC-32 over the bit stream, FCS.
    task automatic push_expected(input bit use_kat, input logic [31:0] kat);
        logic [1:0]  body[$];
        logic [7:0]  pb;
        logic [31:0] c;
        logic [31:0] fcs;
        body = pay;
`ifdef ETH_TX_PAD_EN
        while (body.size() < MinPay) body.push_back(2'b00);
`endif
        for (int b = 0; b < 8; b++) begin
            pb = (b == 7) ? 8'hD5 : 8'h55;
            for (int j = 0; j < 4; j++) exp_d.push_back(pb[2*j +: 2]);
        end
        c = 32'hFFFF_FFFF;
        foreach (body[i]) begin
            exp_d.push_back(body[i]);
            for (int j = 0; j < 2; j++) begin
                if (c[0] ^ body[i][j]) c = (c >> 1) ^ 32'hEDB8_8320;
                else c = c >> 1;
            end
        end
        fcs = use_kat ? kat : ~c;
        for (int j = 0; j < 16; j++) exp_d.push_back(fcs[2*j +: 2]);
        exp_len.push_back(32 + body.size() + 16);
    endtask

    task automatic send(input bit acc, input bit use_kat, input logic [31:0] kat);
        if (acc) push_expected(use_kat, kat);
        foreach (pay[i]) begin
            if (i == 0) begin
                if (acc) start_q.push_back(cyc + 1);
                else drop_q.push_back(cyc + 1);
            end
            bus.axiiv = 1'b1;
            bus.axiid = pay[i];
            tick();
        end
        bus.axiiv = 1'b0;
        bus.axiid = 2'($urandom);
    endtask

    task automatic fill_bytes(input logic [7:0] bv, input int nbytes);
        pay.delete();
        for (int i = 0; i < nbytes; i++)
            for (int j = 0; j < 4; j++) pay.push_back(bv[2*j +: 2]);
    endtask

    task automatic fill_rand(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(2'($urandom));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        bus.axiiv = 1'b0;
        while (bus.busy !== 1'b0 && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) chk("busy_timeout", 32'(n), 32'd0);
        idle($urandom_range(1, 5));
    endtask

    // Monitor
    logic [1:0] act[$];
    bit active;
    bit gap_active;
    int ipg_cnt;
    int junk;
    int nobusy;

    always @(negedge clk) begin
        int n;
        int mism;
        logic [1:0] ed;
        if (in_reset || rst) begin
            active = 0;
            gap_active = 0;
            act.delete();
        end else begin
            if (bus.drop === 1'b1) begin
                if (drop_q.size() == 0) chk("drop_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                else chk("drop_cycle", 32'(cyc), 32'(drop_q.pop_front()));
            end
            if (bus.axiov === 1'b1) begin
                if (!active) begin
                    if (gap_active) chk("ipg_cut_short", 32'(ipg_cnt), 32'(Ipg));
                    gap_active = 0;
                    active = 1;
                    act.delete();
                    nobusy = 0;
                    if (start_q.size() == 0) chk("start_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                    else chk("start_cycle", 32'(cyc), 32'(start_q.pop_front()));
                end
                act.push_back(bus.axiod);
                if (bus.busy !== 1'b1) nobusy++;
            end else begin
                if (bus.axiod !== 2'b00) junk++;
                if (active) begin
                    active = 0;
                    if (exp_len.size() == 0) begin
                        chk("frame_unexpected", 32'(act.size()), 32'd0);
                    end else begin
                        n = exp_len.pop_front();
                        mism = -1;
                        for (int i = 0; i < n; i++) begin
                            ed = exp_d.pop_front();
                            if (mism < 0 && (i >= act.size() || act[i] !== ed)) mism = i;
                        end
                        chk("frame_len", 32'(act.size()), 32'(n));
                        chk("frame_first_bad_idx", 32'(mism), 32'hFFFF_FFFF);
                        chk("busy_low_in_frame", 32'(nobusy), 32'd0);
                    end
                    gap_active = 1;
                    ipg_cnt = 0;
                    junk = 0;
                end
                if (gap_active) begin
                    if (bus.busy === 1'b1) ipg_cnt++;
                    else begin
                        chk("ipg_busy_cycles", 32'(ipg_cnt), 32'(Ipg));
                        chk("axiod_nonzero_idle", 32'(junk), 32'd0);
                        gap_active = 0;
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        fails = 0;
        rst = 1'b1;
        in_reset = 1'b1;
        bus.axiiv = 1'b0;
        bus.axiid = 2'b00;
        repeat (3) tick();
        chk("reset_axiov", 32'(bus.axiov), 32'd0);
        chk("reset_axiod", 32'(bus.axiod), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_drop", 32'(bus.drop), 32'd0);
        rst = 1'b0;
        in_reset = 1'b0;
        idle(3);

        // Known-answer "123456789"
        pay.delete();
        for (int b = 0; b < 9; b++) begin
            logic [7:0] ch;
            ch = 8'h31 + 8'(b);
            for (int j = 0; j < 4; j++) pay.push_back(ch[2*j +: 2]);
        end
`ifdef ETH_TX_PAD_EN
        send(1'b1, 1'b0, 32'h0);
`else
        send(1'b1, 1'b1, 32'hCBF4_3926);
`endif
        wait_idle();

        // Back-to-back: 3-dibit frame, 2-dibit frame 10 cycles later is rejected
        fill_rand(3);
        send(1'b1, 1'b0, 32'h0);
        idle(10);
        fill_rand(2);
        send(1'b0, 1'b0, 32'h0);
        wait_idle();
        fill_rand(5);
        send(1'b1, 1'b0, 32'h0);
        wait_idle();

        // Rejected run still high when the gap ends must stay rejected
        fill_rand(3);
        send(1'b1, 1'b0, 32'h0);
        idle(60);
        fill_rand(80);
        send(1'b0, 1'b0, 32'h0);
        wait_idle();

        // Maximum frame of 0xD2
        fill_bytes(8'hD2, 1500);
        send(1'b1, 1'b0, 32'h0);
        wait_idle();

        // Reset 20 cycles into payload
        fill_rand(100);
        push_expected(1'b0, 32'h0);
        for (int i = 0; i < 53; i++) begin
            if (i == 0) start_q.push_back(cyc + 1);
            bus.axiiv = 1'b1;
            bus.axiid = pay[i];
            tick();
        end
        bus.axiiv = 1'b0;
        rst = 1'b1;
        in_reset = 1'b1;
        exp_d.delete();
        exp_len.delete();
        start_q.delete();
        tick();
        chk("midreset_axiov", 32'(bus.axiov), 32'd0);
        chk("midreset_axiod", 32'(bus.axiod), 32'd0);
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        in_reset = 1'b0;
        idle(4);
        fill_bytes(8'hC5, 2);
        send(1'b1, 1'b0, 32'h0);
        wait_idle();

        // Randomized frames, some followed by a rejected run
        for (int f = 0; f < 12; f++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : $urandom_range(32, 400);
            fill_rand(len);
            send(1'b1, 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 1) begin
                idle($urandom_range(1, 40));
                fill_rand($urandom_range(1, 8));
                send(1'b0, 1'b0, 32'h0);
            end
            wait_idle();
        end

        idle(4);
        chk("frames_outstanding", 32'(exp_len.size()), 32'd0);
        chk("starts_outstanding", 32'(start_q.size()), 32'd0);
        chk("drops_outstanding", 32'(drop_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

- Transmit-side Ethernet framing stage that sits directly downstream of `fifo_data_buffer`.
- Consumes its RMII-width dibit stream (`axiov`/`axiod`, wired here to `axiiv`/`axiid`) and emits a complete wire frame to the RMII TX pins:
  - 7-byte preamble plus SFD prepended;
  - optional minimum-length zero padding;
  - CRC-32 FCS appended;
  - 96-bit inter-packet gap enforced.
- Payload is delayed through a 32-dibit shift buffer so the preamble can be emitted in front of it without back-pressuring upstream.

## Interface

Parameters:
- `IPG_DIBITS`, 48: idle dibits after FCS (12 bytes).
- `MIN_PAYLOAD_DIBITS`, 240: pad threshold (60 bytes); used only with padding compiled in.

Ports:
- `clk`  in  1: system clock (50 MHz RMII reference). Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `axiiv`  in  1: input dibit valid. One contiguous high run is one frame; any low cycle ends the frame.
- `axiid`  in  2: input dibit. Bit 0 is first on the wire.
- `axiov`  out  1: TX enable (RMII `TXEN`).
- `axiod`  out  2: TX dibit (RMII `TXD[1:0]`). Forced to 2'b00 whenever `axiov`=0.
- `busy`  out  1: high from the first accepted dibit through the last IPG cycle.
- `drop`  out  1: one-cycle pulse on the first dibit of a rejected frame.

## Operation

- **States:** IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IPG.
- **IDLE:**
  - `axiiv`=1 → PREAMBLE, and the dibit is written into the buffer.
  - Frame-capture flag `cap` is set.
  - Payload counter is loaded with 1. The counter is 11 bits and saturates at 2047.
- **Capture:**
  - While `cap`=1, every `axiiv`=1 dibit is appended to the buffer and increments the counter.
  - The first `axiiv`=0 clears `cap`.
  - Capture may end in PREAMBLE or PAYLOAD.
- **PREAMBLE:**
  - Emits 32 dibits: 31 × 2'b01, then 2'b11 (bytes 0x55×7, 0xD5, LSB first).
  - Then → PAYLOAD.
- **PAYLOAD:**
  - Emits buffered dibits in arrival order. Each emitted dibit is fed to the CRC.
  - When the buffer is empty and `cap`=0 → PAD, or → FCS if padding is not needed or not compiled in.
  - The buffer can never underrun while `cap`=1, because fill and drain rates are equal.
- **PAD:**
  - Emits 2'b00 (CRC-included) until total payload dibits = `MIN_PAYLOAD_DIBITS`.
  - Then → FCS.
- **CRC:**
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Each dibit processes bit 0 then bit 1: `fb=crc[0]^b; crc=(crc>>1)^(fb?poly:0)`.
  - CRC is reinitialised in IDLE.
- **FCS:**
  - Emits 16 dibits; dibit i = ~crc[2i+1:2i], i=0..15.
  - Then → IPG.
- **IPG:**
  - `axiov`=0 for `IPG_DIBITS` cycles.
  - Then → IDLE, `busy`=0.
- **Rejection:**
  - A rising `axiiv` while state≠IDLE and `cap`=0 starts a rejected frame.
  - The whole contiguous run is ignored; `drop`=1 for its first cycle only.
  - A run still high when IPG ends stays rejected; acceptance requires a fresh rising edge in IDLE.

## Timing

- **Reset values:** `axiov`=0, `axiod`=2'b00, `busy`=0, `drop`=0. State=IDLE, buffer and counter cleared.
- **Registered outputs:** if the first dibit is sampled at edge N:
  - `axiov` rises after edge N;
  - preamble/SFD occupies the outputs after edges N..N+31;
  - payload dibit k (sampled at edge N+k) appears after edge N+32+k. Fixed latency is 32 cycles plus the output register.
- **`busy`:** rises after edge N.
- **`drop`:** asserted the cycle after the rejected dibit is sampled.
- **Frame on the wire:**
  - `axiov` is continuously high from the first preamble dibit to the last FCS dibit.
  - Total high cycles = 32 + max(payload, pad target) + 16.
- **Short frame:** if the frame is shorter than 32 dibits, capture ends during PREAMBLE and PAYLOAD still drains everything captured.
- **Reset mid-frame:** outputs are low after the reset edge and the partial frame is discarded. No FCS is emitted.

## Configuration

- `ETH_TX_PAD_EN` defined:
  - PAD state is present;
  - frames with fewer than `MIN_PAYLOAD_DIBITS` payload dibits are zero-padded before FCS;
  - CRC covers the pad.
- Undefined:
  - PAD state and threshold compare are removed;
  - PAYLOAD → FCS directly;
  - payload counter is not needed.

## Test plan

- **CRC check:** ASCII "123456789" (36 dibits), `ETH_TX_PAD_EN` undefined → 31×01, 11, 36 payload dibits, then FCS 0xCBF43926 LSB first. First FCS dibits are 10,01,10,00 (byte 0x26). `axiov` is high for exactly 84 cycles.
- **Padding:** same 36 dibits with `ETH_TX_PAD_EN` → 204 zero dibits after the payload, then FCS, for 288 high cycles. FCS equals CRC-32 of "123456789" plus 51 zero bytes.
- **Maximum frame:** 1500-byte frame (6000 dibits) of 0xD2 → payload dibits 10,00,01,11 repeating, emitted 32 cycles after input. No gap in `axiov`; `busy` stays high through 48 IPG cycles.
- **Back-to-back rejection:** 3-dibit frame, then a 2-dibit frame starting 10 cycles after the first ends → second frame rejected. `drop` pulses once, with no effect on the first frame's output. A third frame sent after `busy` falls is accepted.
- **Reset mid-frame:** `rst` asserted 20 cycles into PAYLOAD → `axiov`, `axiod`, `busy` = 0 the next cycle. A subsequent 2-dibit frame of 0xC5 is framed correctly with a fresh CRC.
